key_conditioner: RTL
====================

# key_conditioner

Conditions one raw mechanical push-button for the stopwatch datapath. It synchronises the key, debounces it in both directions, and emits single-cycle press, release and long-press strobes plus a clean level. Its press_pulse is the direct source of the stopwatch's pause_resume input, which must be one clock wide per physical press. long_pulse is available to board-level logic as a clear request.

## Interface
- CLK_HZ, 50_000_000, clock frequency; documentation only, no logic depends on it.
- DEBOUNCE_CYCLES, 1_000_000, stable-sample count needed to accept a press or release (20 ms at 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 100_000_000, hold time after the accepted press before long_pulse (2 s); legal range ≥ 1.
- ACTIVE_LOW, 0; 1 means the raw key reads 0 when pressed.
- clk  input  1  system clock.
- reset_start  input  1  asynchronous, active-high reset.
- key_in  input  1  raw key, asynchronous to clk, bouncing.
- key_level  output  1  debounced level; 1 = pressed.
- press_pulse  output  1  one-cycle strobe when a press is accepted.
- release_pulse  output  1  one-cycle strobe when a release is accepted.
- long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.

## Operation
- Synchroniser:
  - Two flops; both reset to the released raw value (ACTIVE_LOW ? 1 : 0).
  - key_s is the second flop, polarity-normalised so that 1 = pressed.
- Counters:
  - deb_cnt is sized with $clog2(DEBOUNCE_CYCLES).
  - hold_cnt is sized with $clog2(LONG_CYCLES).
  - Both saturate; they never wrap.
- FSM states and transitions:
  - IDLE: key_level=0. key_s=1 → PRESS_WAIT with deb_cnt=1.
  - PRESS_WAIT:
    - key_s=0 → IDLE (bounce rejected, no pulse).
    - key_s=1 with deb_cnt==DEBOUNCE_CYCLES-1 → PRESSED. press_pulse=1 for one cycle, key_level=1, hold_cnt=0.
    - Otherwise deb_cnt++.
  - PRESSED:
    - key_s=0 → RELEASE_WAIT with deb_cnt=1.
    - Else hold_cnt++.
    - hold_cnt==LONG_CYCLES-1 → LONG_HELD with long_pulse=1 for one cycle.
  - LONG_HELD: key_s=0 → RELEASE_WAIT with deb_cnt=1. long_pulse never repeats.
  - RELEASE_WAIT:
    - key_level stays 1 and hold_cnt is frozen.
    - key_s=1 → return to PRESSED or LONG_HELD, whichever was left (1-bit long_seen flag). No pulse is emitted.
    - key_s=0 with deb_cnt==DEBOUNCE_CYCLES-1 → IDLE. release_pulse=1 for one cycle, key_level=0, long_seen=0.
    - Otherwise deb_cnt++.
- All outputs are registered.
- At most one of press_pulse, release_pulse, long_pulse is high in any cycle.
- Reset:
  - reset_start forces IDLE, clears both counters and long_seen, and drives all outputs to 0 immediately (asynchronous).
  - Applies mid-debounce or mid-hold; no pulse is emitted on reset entry or exit.
  - A key held through reset deassertion is treated as a fresh press: press_pulse appears after the normal debounce.

## Timing
- Let e be the first clk edge that samples key_in pressed.
- Press: if key_in stays pressed, press_pulse and key_level rise at edge e+DEBOUNCE_CYCLES+2. This is 2 edges of synchroniser plus DEBOUNCE_CYCLES stable FSM samples.
- Release: same latency, measured from the first edge that samples key_in released.
- Long press: long_pulse rises exactly LONG_CYCLES edges after press_pulse rises.
- Any opposite-level sample at the FSM restarts the debounce window; partial windows never produce pulses.
- Each pulse is exactly one clk cycle wide.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=0.
- Clean press, e=10, key held 10 edges then released → press_pulse high only in the cycle after edge 16. key_level high from edge 16 until release_pulse (release edge + 6). No long_pulse.
- Bounce: key toggles 1,0,1,0 on consecutive edges, then holds 1 → no pulse during bounce. Exactly one press_pulse, 6 edges after the final stable 1 is first sampled.
- Long hold: press held 40 edges → press_pulse at e+6, long_pulse at e+22. Single release_pulse after release. No second long_pulse.
- Release bounce during LONG_HELD: 2-edge low glitch → no release_pulse. key_level stays 1. FSM returns to LONG_HELD with no extra long_pulse.
- Reset mid-PRESS_WAIT: reset_start asserted at e+3 for 2 cycles with the key still held → outputs 0 during reset. After deassertion, press_pulse at (first post-reset edge)+6. No pulse in between.
- ACTIVE_LOW=1: key_in held 0 from edge 5 → press_pulse at edge 11. key_in idle 1 produces no activity out of reset.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-decodes one raw push-button.
// Produces a clean pressed level plus one-cycle press, release and long-press strobes.
module key_conditioner #(
   parameter int unsigned CLK_HZ          = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic reset_start,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   // Reject parameter sets the counters cannot represent.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $error("key_conditioner: LONG_CYCLES must be >= 1");
   end
   if (CLK_HZ == 0) begin : g_bad_clk
      $error("key_conditioner: CLK_HZ must be non-zero");
   end

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      LONG_HELD,
      RELEASE_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic            key_s;
   logic [DW-1:0]   deb_q, deb_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            long_seen_q, long_seen_d;
   logic            press_d, rel_d, long_d;
   logic [2:0]      evt_q;

   // Two-flop synchroniser, reset to the released raw level.
   always_ff @(posedge clk or posedge reset_start) begin
      if (reset_start) begin
         sync_q <= {2{ACTIVE_LOW}};
      end else begin
         sync_q <= {sync_q[0], key_in};
      end
   end

   assign key_s = sync_q[1] ^ ACTIVE_LOW;

   // State, counters and transition strobes.
   always_ff @(posedge clk or posedge reset_start) begin
      if (reset_start) begin
         state_q     <= IDLE;
         deb_q       <= '0;
         hold_q      <= '0;
         long_seen_q <= 1'b0;
         evt_q       <= '0;
      end else begin
         state_q     <= state_d;
         deb_q       <= deb_d;
         hold_q      <= hold_d;
         long_seen_q <= long_seen_d;
         evt_q       <= {long_d, rel_d, press_d};
      end
   end

   // Next-state logic; counters saturate instead of wrapping.
   always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_seen_d = long_seen_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_s) begin
               state_d = PRESS_WAIT;
               deb_d   = DW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               state_d = IDLE;
            end else if (deb_q == DEB_LAST) begin
               state_d = PRESSED;
               press_d = 1'b1;
               hold_d  = '0;
            end else if (deb_q != '1) begin
               deb_d = deb_q + DW'(1);
            end
         end
         PRESSED: begin
            if (!key_s) begin
               state_d = RELEASE_WAIT;
               deb_d   = DW'(1);
            end else if (hold_q == HOLD_LAST) begin
               state_d     = LONG_HELD;
               long_d      = 1'b1;
               long_seen_d = 1'b1;
            end else if (hold_q != '1) begin
               hold_d = hold_q + HW'(1);
            end
         end
         LONG_HELD: begin
            if (!key_s) begin
               state_d = RELEASE_WAIT;
               deb_d   = DW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (key_s) begin
               state_d = long_seen_q ? LONG_HELD : PRESSED;
            end else if (deb_q == DEB_LAST) begin
               state_d     = IDLE;
               rel_d       = 1'b1;
               long_seen_d = 1'b0;
            end else if (deb_q != '1) begin
               deb_d = deb_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register stage: the level and strobes leave the block flop-driven and
   // mutually aligned one clock after the state transition that caused them.
   always_ff @(posedge clk or posedge reset_start) begin
      if (reset_start) begin
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
      end else begin
         key_level     <= (state_q == PRESSED) || (state_q == LONG_HELD) ||
                          (state_q == RELEASE_WAIT);
         press_pulse   <= evt_q[0];
         release_pulse <= evt_q[1];
         long_pulse    <= evt_q[2];
      end
   end

endmodule
